// File: rtl/counter_seq_ctrl.sv
// Run/stop sequencer around a WIDTH-bit up-counter (one-shot or periodic).
// Optional prescaler: define COUNTER_CTRL_PRESCALE_EN to divide count advance by PRESCALE.
module counter_seq_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             abort,
    input  logic             mode,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] term_q;
    logic [WIDTH-1:0] term_n;
    logic             mode_q;
    logic             mode_n;
    logic             tick_n;
    logic             done_n;

    logic st_idle;
    logic st_run;
    logic st_hold;
    logic launch;
    logic running;
    logic at_term;
    logic adv;

    assign st_idle = (state == IDLE);
    assign st_run  = (state == RUN);
    assign st_hold = (state == HOLD);
    assign at_term = (count == term_q);

    assign launch  = st_idle & start & (|term) & ~abort;
    assign running = st_run & ~stop & ~abort;

`ifdef COUNTER_CTRL_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

    logic [PW-1:0] psc;
    logic [PW-1:0] psc_n;

    assign adv = (psc == PLAST);

    // Prescaler only moves while the counter itself is allowed to move.
    always_comb begin
        psc_n = psc;
        if (abort || launch) begin
            psc_n = '0;
        end else if (running) begin
            psc_n = adv ? '0 : psc + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psc <= '0;
        end else begin
            psc <= psc_n;
        end
    end
`else
    assign adv = (PRESCALE >= 1);
`endif

    always_comb begin
        state_n = state;
        count_n = count;
        term_n  = term_q;
        mode_n  = mode_q;
        tick_n  = 1'b0;
        done_n  = 1'b0;
        if (abort) begin
            state_n = IDLE;
            count_n = '0;
        end else begin
            unique case (1'b1)
                st_idle: begin
                    if (launch) begin
                        term_n  = term;
                        mode_n  = mode;
                        count_n = '0;
                        state_n = RUN;
                    end
                end
                st_run: begin
                    if (stop) begin
                        state_n = HOLD;
                    end else if (adv) begin
                        if (at_term) begin
                            count_n = '0;
                            tick_n  = 1'b1;
                            if (!mode_q) begin
                                state_n = IDLE;
                                done_n  = 1'b1;
                            end
                        end else begin
                            count_n = count + WIDTH'(1);
                        end
                    end
                end
                st_hold: begin
                    if (start) begin
                        state_n = RUN;
                    end
                end
                default: begin
                    state_n = IDLE;
                    count_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            count  <= '0;
            term_q <= '0;
            mode_q <= 1'b0;
            tick   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            term_q <= term_n;
            mode_q <= mode_n;
            tick   <= tick_n;
            done   <= done_n;
        end
    end

    assign busy = ~st_idle;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl: directed vectors, per-edge expectations.
// Build with COUNTER_CTRL_PRESCALE_EN to run the prescaler vectors instead.
module tb_counter_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       abort;
    logic       mode;
    logic [3:0] term;
    logic [3:0] count;
    logic       busy;
    logic       tick;
    logic       done;

    int n_cmp;
    int n_err;

    typedef struct {
        logic [3:0] c;
        logic       b;
        logic       t;
        logic       d;
        string      nm;
    } exp_t;

    exp_t sb[$];
    event chk_ev;

    counter_seq_ctrl #(.WIDTH(4), .PRESCALE(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .stop (stop),
        .abort(abort),
        .mode (mode),
        .term (term),
        .count(count),
        .busy (busy),
        .tick (tick),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [3:0] c, input logic b, input logic t,
                        input logic d, input string nm);
        exp_t e;
        e.c  = c;
        e.b  = b;
        e.t  = t;
        e.d  = d;
        e.nm = nm;
        sb.push_back(e);
    endtask

    // Drive inputs for the next rising edge and queue the state expected after it.
    task automatic step(input logic s, input logic sp, input logic ab,
                        input logic m, input logic [3:0] tm,
                        input logic [3:0] c, input logic b, input logic t,
                        input logic d, input string nm);
        @(negedge clk);
        rst   = 1'b1;
        start = s;
        stop  = sp;
        abort = ab;
        mode  = m;
        term  = tm;
        push(c, b, t, d, nm);
    endtask

    task automatic idle(input logic [3:0] c, input logic b, input logic t,
                        input logic d, input string nm);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, c, b, t, d, nm);
    endtask

    task automatic kill(input string nm);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, nm);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk or chk_ev);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_cmp++;
                if ({count, busy, tick, done} !== {e.c, e.b, e.t, e.d}) begin
                    n_err++;
                    $display("FAIL %s: got count=%0d busy=%0b tick=%0b done=%0b want count=%0d busy=%0b tick=%0b done=%0b",
                             e.nm, count, busy, tick, done, e.c, e.b, e.t, e.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        start = 1'b1;
        stop  = 1'b0;
        abort = 1'b0;
        mode  = 1'b1;
        term  = 4'd3;
        push(4'd0, 1'b0, 1'b0, 1'b0, "rst_hold");
        idle(4'd0, 1'b0, 1'b0, 1'b0, "rst_release");

`ifdef COUNTER_CTRL_PRESCALE_EN
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, "ps_start");
        for (int k = 1; k <= 14; k++) begin
            idle(4'((k / 4) % 3), 1'b1, (k == 12), 1'b0, "ps_run");
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, "ps_stop");
        idle(4'd0, 1'b1, 1'b0, 1'b0, "ps_hold");
        idle(4'd0, 1'b1, 1'b0, 1'b0, "ps_hold");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, "ps_resume");
        idle(4'd0, 1'b1, 1'b0, 1'b0, "ps_psc_last");
        idle(4'd1, 1'b1, 1'b0, 1'b0, "ps_step");
        kill("ps_abort");
`else
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, "per_start");
        for (int i = 1; i <= 8; i++) begin
            idle(4'(i % 4), 1'b1, (i % 4 == 0), 1'b0, "per_run");
        end
        kill("per_abort");

        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0, "os_start");
        for (int i = 1; i <= 5; i++) begin
            idle(4'(i), 1'b1, 1'b0, 1'b0, "os_run");
        end
        idle(4'd0, 1'b0, 1'b1, 1'b1, "os_done");
        idle(4'd0, 1'b0, 1'b0, 1'b0, "os_after");

        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0, "pr_start");
        idle(4'd1, 1'b1, 1'b0, 1'b0, "pr_run");
        idle(4'd2, 1'b1, 1'b0, 1'b0, "pr_run");
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, "pr_stop");
        idle(4'd2, 1'b1, 1'b0, 1'b0, "pr_hold");
        idle(4'd2, 1'b1, 1'b0, 1'b0, "pr_hold");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, "pr_resume");
        for (int i = 3; i <= 7; i++) begin
            idle(4'(i), 1'b1, 1'b0, 1'b0, "pr_run2");
        end
        idle(4'd0, 1'b1, 1'b1, 1'b0, "pr_tick");
        kill("pr_abort");

        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, "pt_start");
        idle(4'd1, 1'b1, 1'b0, 1'b0, "pt_run");
        idle(4'd2, 1'b1, 1'b0, 1'b0, "pt_run");
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, "pt_stop_at_term");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, "pt_resume");
        idle(4'd0, 1'b1, 1'b1, 1'b0, "pt_tick");
        kill("pt_abort");

        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "term0_start");
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, "idle_stop");

        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 4'd0, 1'b1, 1'b0, 1'b0, "ig_start");
        idle(4'd1, 1'b1, 1'b0, 1'b0, "ig_run");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0, "ig_restart");
        idle(4'd3, 1'b1, 1'b0, 1'b0, "ig_run");
        idle(4'd4, 1'b1, 1'b0, 1'b0, "ig_run");
        idle(4'd0, 1'b1, 1'b1, 1'b0, "ig_tick");
        for (int i = 1; i <= 4; i++) begin
            idle(4'(i), 1'b1, 1'b0, 1'b0, "ig_run2");
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'd5, 4'd0, 1'b0, 1'b0, 1'b0, "abort_all");
        idle(4'd0, 1'b0, 1'b0, 1'b0, "abort_idle");

        step(1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 4'd0, 1'b1, 1'b0, 1'b0, "wr_start");
        for (int i = 1; i <= 15; i++) begin
            idle(4'(i), 1'b1, 1'b0, 1'b0, "wr_run");
        end
        idle(4'd0, 1'b0, 1'b1, 1'b1, "wr_done");

        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 4'd0, 1'b1, 1'b0, 1'b0, "rs_start");
        for (int i = 1; i <= 3; i++) begin
            idle(4'(i), 1'b1, 1'b0, 1'b0, "rs_run");
        end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        abort = 1'b0;
        push(4'd0, 1'b0, 1'b0, 1'b0, "rs_async");
        ->chk_ev;
        push(4'd0, 1'b0, 1'b0, 1'b0, "rs_held");
        idle(4'd0, 1'b0, 1'b0, 1'b0, "rs_release");
        idle(4'd0, 1'b0, 1'b0, 1'b0, "rs_idle");
        step(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, "rs_start2");
        idle(4'd1, 1'b1, 1'b0, 1'b0, "rs_run2");
        idle(4'd0, 1'b1, 1'b1, 1'b0, "rs_tick");
        kill("rs_abort");
`endif

        for (int w = 0; w < 10 && sb.size() != 0; w++) begin
            @(posedge clk);
            #3;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Run/stop controller wrapped around a WIDTH-bit synchronous up-counter.
- Sequences the counter through start, pause, resume and abort commands.
- Runs one-shot or periodic up to a programmable terminal count.
- Emits a tick pulse on each wrap and a done pulse when a one-shot run completes.
- Used as the event and timebase generator for sequential blocks in the same design.

Parameters:
WIDTH, 4, width of count and term.
PRESCALE, 4, count-advance divider; used only when COUNTER_CTRL_PRESCALE_EN is defined; must be >= 1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset; asynchronous, active-low (0 = reset).
start  input  1  in IDLE: load term/mode and begin; in HOLD: resume.
stop  input  1  in RUN: pause (enter HOLD).
abort  input  1  any state: return to IDLE and clear count.
mode  input  1  0 = one-shot, 1 = periodic; sampled at start from IDLE.
term  input  WIDTH  terminal count; sampled at start from IDLE.
count  output  WIDTH  current count value (registered).
busy  output  1  1 while in RUN or HOLD; decoded from the state register.
tick  output  1  one-cycle registered pulse on each wrap.
done  output  1  one-cycle registered pulse when a one-shot run completes.

Behaviour:
Reset (rst=0, asynchronous):
- state=IDLE, count=0, term_q=0, mode_q=0, tick=0, done=0, busy=0.

General:
- tick and done default to 0 each cycle; each is high for exactly one cycle when set.
- Command priority: abort > stop > start.

States:
- IDLE:
  - start=1 and term!=0: term_q<=term, mode_q<=mode, count<=0, go to RUN.
  - start=1 and term==0: ignored; stay in IDLE.
  - stop: ignored.
- RUN:
  - stop=1: go to HOLD; count frozen; no tick, even when count==term_q.
  - else if count==term_q: count<=0 and tick<=1 on the next edge.
    - mode_q=1: stay in RUN.
    - mode_q=0: go to IDLE and done<=1 on the same edge (busy falls on that edge).
  - else: count<=count+1.
  - start: ignored; term/mode are not reloaded.
- HOLD:
  - start=1: go to RUN; count resumes from its held value; term/mode not reloaded.
  - stop: ignored.
- abort=1 in any state: go to IDLE, count<=0, no tick or done, overrides start and stop in the same cycle.

Timing:
- Count runs 0..term_q, so the period is term_q+1 cycles.
- First tick: count=0 on the start edge; tick is high in the cycle after the (term_q+1)th edge after start.
- Width: count is modulo 2^WIDTH; term=2^WIDTH-1 gives a natural wrap with identical tick timing.
- A pause taken while count==term_q defers the wrap and tick to the first RUN cycle after resume.

Optional Feature:
Macro: COUNTER_CTRL_PRESCALE_EN
- Defined:
  - Internal prescaler counts 0..PRESCALE-1 during RUN.
  - count advance, wrap, tick and done occur only in cycles where prescaler==PRESCALE-1.
  - Prescaler is held in HOLD and cleared on reset, on start from IDLE, and on abort.
  - Period = (term_q+1)*PRESCALE cycles.
  - PRESCALE=1 behaves identically to undefined.
- Undefined: no prescaler logic; PRESCALE ignored; advance every RUN cycle.

Test Plan:
1. Periodic: mode=1, term=3, start pulse -> count 0,1,2,3,0,1...; tick high 1 cycle every 4 cycles; busy stays 1; done never asserts.
2. One-shot: mode=0, term=5, start -> count 0..5; on the 6th edge after start: count=0, tick=1, done=1, busy=0; state IDLE; further cycles idle.
3. Pause/resume: term=7, stop when count=2, hold 3 cycles, then start -> count stays 2 through HOLD with busy=1; resumes 3,4..; tick delayed by exactly the hold length.
4. Edge commands:
   - start with term=0 -> stays IDLE, busy=0.
   - abort+start in the same cycle during RUN at count=4 -> IDLE, count=0, no tick.
   - start during RUN -> ignored.
5. Reset mid-run: drop rst at count=3 asynchronously -> count, busy, tick, done go to 0 immediately; after release, idle until start.
6. With COUNTER_CTRL_PRESCALE_EN, PRESCALE=4, term=2, mode=1 -> count steps every 4 cycles; tick every 12 cycles; stop holds both prescaler and count.
